serial_addsub_ctrl: RTL and testbench

Bit-serial add/subtract controller that time-shares one full add/subtract bit cell over WIDTH cycles, LSB first. The cell is built from two half_operator instances (sum/diff plus carry/borrow). It accepts a start request with operands and an opcode, sequences one bit per clock, and returns an N-bit result with carry-out/borrow-out and a one-cycle DONE pulse. It sits between a requester (sequencer or testbench) and the arithmetic cell, and replaces a WIDTH-bit parallel adder where area matters more than latency.

---
 rtl/serial_addsub_pkg.sv | 14 +
 rtl/full_operator.sv | 44 ++++
 rtl/half_operator.sv | 19 +
 rtl/serial_addsub_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// controller state encoding and opcode values.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_operator.sv
// Combinational full add/subtract bit cell built from two half cells.
// Ports: X, Y - operand bits; CI - carry/borrow in; OP - 0 add, 1 sub
//        R    - result bit;     CO - carry-out (add) / borrow-out (sub)
module full_operator
    import serial_addsub_pkg::*;
(
    input  logic X,
    input  logic Y,
    input  logic CI,
    input  logic OP,
    output logic R,
    output logic CO
);

    logic s1, c1, d1, b1;
    logic x2;
    logic s2, c2, d2, b2;

    half_operator u_stage1 (
        .X (X),
        .Y (Y),
        .S (s1),
        .C (c1),
        .D (d1),
        .B (b1)
    );

    // Sum and difference of the first stage are the same bit; selecting by
    // opcode keeps the stage-2 input sourced from the path actually in use.
    assign x2 = (OP == OP_SUB) ? d1 : s1;

    half_operator u_stage2 (
        .X (x2),
        .Y (CI),
        .S (s2),
        .C (c2),
        .D (d2),
        .B (b2)
    );

    assign R  = (OP == OP_SUB) ? d2 : s2;
    assign CO = (OP == OP_SUB) ? (b1 | b2) : (c1 | c2);

endmodule

// File: rtl/half_operator.sv
// Half add/subtract bit cell.
// Ports: X, Y  - operand bits (X - Y for the difference path)
//        S, C  - half-add sum and carry
//        D, B  - half-subtract difference and borrow
module half_operator (
    input  logic X,
    input  logic Y,
    output logic S,
    output logic C,
    output logic D,
    output logic B
);

    assign S = X ^ Y;
    assign C = X & Y;
    assign D = X ^ Y;
    assign B = ~X & Y;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one full_operator cell processes one
// bit per clock, LSB first, over WIDTH cycles.
// Ports: clk, rst (async, active-high)
//        START, OP, A, B - request with opcode and operands (sampled in IDLE)
//        BUSY            - high while an op is in RUN or FIN
//        DONE            - one-cycle pulse, R/COUT valid
//        R, COUT         - result and carry-out / borrow-out
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    input  logic             OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] R,
    output logic             COUT
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               bit_r;
    logic               bit_co;

    full_operator u_cell (
        .X  (a_q[cnt_q]),
        .Y  (b_q[cnt_q]),
        .CI (c_q),
        .OP (op_q),
        .R  (bit_r),
        .CO (bit_co)
    );

    // Next-state and datapath updates; BUSY/DONE derived from the next state
    // so they are registered alongside it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        r_d     = r_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = OP;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    r_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                r_d[cnt_q] = bit_r;
                c_d        = bit_co;
                if (cnt_q == CNT_LAST) begin
                    cout_d  = bit_co;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            r_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            r_q     <= r_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign R    = r_q;
    assign COUT = cout_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl (WIDTH=8) with hand-computed results.
module tb_serial_addsub_ctrl;

    logic       clk;
    logic       rst;
    logic       START;
    logic       OP;
    logic [7:0] A;
    logic [7:0] B;
    logic       BUSY;
    logic       DONE;
    logic [7:0] R;
    logic       COUT;

    int n_checks;
    int n_errors;

    serial_addsub_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .START (START),
        .OP    (OP),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .R     (R),
        .COUT  (COUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: plain op; 1: corrupt A/B during RUN; 2: hold START high with A=50
    // through RUN and the DONE cycle. Called 1 time unit after a rising edge.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic op, input logic [7:0] er, input logic ecout,
                          input int mode);
        int  lat;
        int  busy_cnt;
        bit  seen;
        START = 1'b1;
        A     = a;
        B     = b;
        OP    = op;
        @(posedge clk); #1;
        if (mode == 2) begin
            A = 8'd50;
        end else begin
            START = 1'b0;
        end
        if (mode == 1) begin
            A = 8'hFF;
            B = 8'hFF;
        end
        busy_cnt = BUSY ? 1 : 0;
        lat      = 0;
        seen     = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (BUSY) busy_cnt++;
            if (DONE) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_r"}, 32'(R), 32'(er));
        check({tag, "_cout"}, 32'(COUT), 32'(ecout));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
        @(posedge clk); #1;
        check({tag, "_done_pulse_end"}, 32'(DONE), 32'd0);
        check({tag, "_busy_end"}, 32'(BUSY), 32'd0);
        START = 1'b0;
        A     = 8'd0;
        B     = 8'd0;
        if (mode == 2) begin
            @(posedge clk); #1;
            check({tag, "_no_second_op"}, 32'(BUSY), 32'd0);
            check({tag, "_r_held"}, 32'(R), 32'(er));
        end
    endtask

    initial begin
        bit done_seen;
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        START = 1'b0;
        OP    = 1'b0;
        A     = 8'd0;
        B     = 8'd0;
        #2;
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_r", 32'(R), 32'd0);
        check("reset_cout", 32'(COUT), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add_5_3",    8'd5,   8'd3,   1'b0, 8'd8,   1'b0, 0);
        run_op("add_ovf",    8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 0);
        run_op("add_ripple", 8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 0);
        run_op("sub_borrow", 8'd5,   8'd9,   1'b1, 8'd252, 1'b1, 0);
        run_op("sub_plain",  8'd9,   8'd5,   1'b1, 8'd4,   1'b0, 0);
        run_op("sub_equal",  8'h5A,  8'h5A,  1'b1, 8'd0,   1'b0, 0);
        run_op("busy_rej",   8'd1,   8'd1,   1'b0, 8'd2,   1'b0, 2);
        run_op("opnd_chg",   8'd10,  8'd20,  1'b0, 8'd30,  1'b0, 1);

        // Abort an add of 3+4 after four bits have been written.
        START = 1'b1;
        A     = 8'd3;
        B     = 8'd4;
        OP    = 1'b0;
        @(posedge clk); #1;
        START = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_r", 32'(R), 32'd7);
        check("mid_busy", 32'(BUSY), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_busy", 32'(BUSY), 32'd0);
        check("rst_async_done", 32'(DONE), 32'd0);
        check("rst_async_r", 32'(R), 32'd0);
        check("rst_async_cout", 32'(COUT), 32'd0);
        done_seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (DONE) done_seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (DONE) done_seen = 1'b1;
        end
        check("rst_no_done", 32'(done_seen), 32'd0);
        run_op("post_rst", 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
